tt_um_counter_host: RTL and testbench



---
 rtl/tt_um_counter_host_pkg.sv | 23 ++
 rtl/tt_um_counter_host_checker.sv | 49 ++++
 rtl/tt_um_counter_host.sv | 145 ++++++++++++++
 tb/tb_tt_um_counter_host.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/tt_um_counter_host_pkg.sv
// Shared definitions for the counter-host tile: FSM encoding, uo_out bit map
// and the fixed seed/error constants.
package tt_um_counter_host_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_WRITE = 3'd1,
    ST_TURN  = 3'd2,
    ST_READ  = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  localparam int UO_LOAD    = 0;
  localparam int UO_OE      = 1;
  localparam int UO_BUSY    = 2;
  localparam int UO_PASS    = 3;
  localparam int UO_FAIL    = 4;
  localparam int UO_ERR_LSB = 5;

  localparam logic [1:0] SEED_LSBS = 2'b11;
  localparam logic [2:0] ERR_MAX   = 3'd7;

endpackage

// File: rtl/tt_um_counter_host_checker.sv
// Readback checker: tracks the expected counter value, compares each sample
// and keeps a sticky fail flag plus a saturating mismatch count.
module tt_um_counter_host_checker
  import tt_um_counter_host_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_clr,
  input  logic       i_load,
  input  logic [7:0] i_load_val,
  input  logic       i_sample,
  input  logic [7:0] i_data,
  output logic       o_fail,
  output logic       o_fail_next,
  output logic [2:0] o_err_cnt
);

  logic [7:0] r_expect;
  logic       w_mismatch;

  function automatic logic [2:0] sat_inc(input logic [2:0] v);
    return (v == ERR_MAX) ? v : v + 3'd1;
  endfunction

  assign w_mismatch  = i_sample && (i_data != r_expect);
  // Lets the host fold the final sample into pass on the same edge it enters DONE.
  assign o_fail_next = o_fail | w_mismatch;

  always_ff @(posedge clk) begin
    if (i_load)
      r_expect <= i_load_val;
    else if (i_sample)
      r_expect <= r_expect + 8'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_fail    <= 1'b0;
      o_err_cnt <= 3'd0;
    end else if (i_clr) begin
      o_fail    <= 1'b0;
      o_err_cnt <= 3'd0;
    end else if (w_mismatch) begin
      o_fail    <= 1'b1;
      o_err_cnt <= sat_inc(o_err_cnt);
    end
  end

endmodule

// File: rtl/tt_um_counter_host.sv
// Bus master for the load/readback counter tile: writes a seed, turns the
// shared uio bus around, then checks READ_CYCLES consecutive +1 samples.
module tt_um_counter_host
  import tt_um_counter_host_pkg::*;
#(
  parameter int READ_CYCLES = 16,
  parameter int TURN_CYCLES = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  localparam logic [3:0] TURN_LAST = 4'(TURN_CYCLES - 1);
  localparam logic [7:0] READ_LAST = 8'(READ_CYCLES - 1);
  localparam logic [7:0] TURN_ADD  = 8'(TURN_CYCLES);

  state_t     r_state;
  logic       r_start_q, r_armed;
  logic       r_load, r_oe, r_busy, r_pass;
  logic [7:0] r_seed, r_uio_out, r_uio_oe;
  logic [3:0] r_turn_cnt;
  logic [7:0] r_cyc_cnt;
  logic       w_abort, w_start_evt, w_go, w_load_exp, w_sample;
  logic       w_fail, w_fail_next;
  logic [2:0] w_err_cnt;
  logic [7:0] w_seed_in;
  logic       w_unused_ok;

  assign w_unused_ok = ena;
  assign w_abort     = ui_in[1];
  assign w_seed_in   = {ui_in[7:2], SEED_LSBS};
  // r_armed requires start to have been seen low since reset, so a level
  // held high across reset release does not launch a run.
  assign w_start_evt = ui_in[0] & ~r_start_q & r_armed & ~w_abort;
  assign w_go        = w_start_evt && (r_state == ST_IDLE || r_state == ST_DONE);
  assign w_load_exp  = !w_abort && r_state == ST_TURN && r_turn_cnt == TURN_LAST;
  assign w_sample    = !w_abort && r_state == ST_READ;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_start_q <= 1'b0;
      r_armed   <= 1'b0;
    end else begin
      r_start_q <= ui_in[0];
      r_armed   <= r_armed | ~ui_in[0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_load     <= 1'b0;
      r_oe       <= 1'b0;
      r_busy     <= 1'b0;
      r_pass     <= 1'b0;
      r_seed     <= 8'd0;
      r_uio_out  <= 8'd0;
      r_uio_oe   <= 8'd0;
      r_turn_cnt <= 4'd0;
      r_cyc_cnt  <= 8'd0;
    end else if (w_abort) begin
      r_state   <= ST_IDLE;
      r_load    <= 1'b0;
      r_oe      <= 1'b0;
      r_busy    <= 1'b0;
      r_pass    <= 1'b0;
      r_uio_out <= 8'd0;
      r_uio_oe  <= 8'd0;
    end else begin
      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (w_go) begin
            r_state    <= ST_WRITE;
            r_seed     <= w_seed_in;
            r_uio_out  <= w_seed_in;
            r_uio_oe   <= 8'hFF;
            r_load     <= 1'b1;
            r_busy     <= 1'b1;
            r_pass     <= 1'b0;
            r_turn_cnt <= 4'd0;
            r_cyc_cnt  <= 8'd0;
          end
        end
        ST_WRITE: begin
          r_state   <= ST_TURN;
          r_uio_out <= 8'd0;
          r_uio_oe  <= 8'd0;
          r_load    <= 1'b0;
        end
        ST_TURN: begin
          if (r_turn_cnt == TURN_LAST) begin
            r_state <= ST_READ;
            r_oe    <= 1'b1;
          end else begin
            r_turn_cnt <= r_turn_cnt + 4'd1;
          end
        end
        ST_READ: begin
          if (r_cyc_cnt == READ_LAST) begin
            r_state <= ST_DONE;
            r_oe    <= 1'b0;
            r_busy  <= 1'b0;
            r_pass  <= !w_fail_next;
          end else begin
            r_cyc_cnt <= r_cyc_cnt + 8'd1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  tt_um_counter_host_checker u_checker (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_clr       (w_go | w_abort),
    .i_load      (w_load_exp),
    .i_load_val  (r_seed + TURN_ADD),
    .i_sample    (w_sample),
    .i_data      (uio_in),
    .o_fail      (w_fail),
    .o_fail_next (w_fail_next),
    .o_err_cnt   (w_err_cnt)
  );

  always_comb begin
    uo_out                     = 8'd0;
    uo_out[UO_LOAD]            = r_load;
    uo_out[UO_OE]              = r_oe;
    uo_out[UO_BUSY]            = r_busy;
    uo_out[UO_PASS]            = r_pass;
    uo_out[UO_FAIL]            = w_fail;
    uo_out[UO_ERR_LSB +: 3]    = w_err_cnt;
  end

  assign uio_out = r_uio_out;
  assign uio_oe  = r_uio_oe;

endmodule

// File: tb/tb_tt_um_counter_host.sv
// Bench for tt_um_counter_host: a behavioural counter tile answers on uio_in,
// and each run's readback is scored against seed + turnaround + k arithmetic.
module tb_tt_um_counter_host;

  localparam int TURN  = 1;
  localparam int READS = 16;

  logic       clk, rst_n;
  logic [7:0] ui_in, uo_out, uio_in, uio_out, uio_oe;
  logic [7:0] r_cnt;
  logic       stuck_on, fault_on;
  logic [7:0] fault_val;
  int         n_asserts = 0;
  int         n_fail    = 0;

  tt_um_counter_host #(.READ_CYCLES(READS), .TURN_CYCLES(TURN)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ena     (1'b1),
    .ui_in   (ui_in),
    .uo_out  (uo_out),
    .uio_in  (uio_in),
    .uio_out (uio_out),
    .uio_oe  (uio_oe)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Counter tile: loads on load_o with the bus driven, otherwise free-runs;
  // the optional fault makes it jump over fault_val.
  always @(posedge clk) begin
    if (uio_oe == 8'hFF && uo_out[0])
      r_cnt <= uio_out;
    else if (fault_on && r_cnt == fault_val - 8'd1)
      r_cnt <= fault_val + 8'd1;
    else
      r_cnt <= r_cnt + 8'd1;
  end

  assign uio_in = stuck_on ? 8'h00 : r_cnt;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic run_one(input logic [5:0] s6, input int mode, input logic [7:0] fval, input bit hold);
    logic [7:0] seed, want;
    int mis;
    seed      = {s6, 2'b11};
    stuck_on  = (mode == 1);
    fault_on  = (mode == 2);
    fault_val = fval;
    @(negedge clk); ui_in = 8'h00;
    @(negedge clk);
    @(negedge clk); ui_in = {s6, 2'b01};
    @(posedge clk); #1;
    check("write_uio_oe", uio_oe, 8'hFF);
    check("write_uio_out", uio_out, seed);
    check("write_load", uo_out[0], 1);
    check("write_oe_o", uo_out[1], 0);
    check("write_busy", uo_out[2], 1);
    @(negedge clk); if (!hold) ui_in[0] = 1'b0;
    @(posedge clk); #1;
    check("turn_uio_oe", uio_oe, 8'h00);
    check("turn_uio_out", uio_out, 8'h00);
    check("turn_load", uo_out[0], 0);
    check("turn_oe_o", uo_out[1], 0);
    repeat (TURN) @(posedge clk);
    #1;
    check("read_oe_o", uo_out[1], 1);
    mis = 0;
    for (int k = 0; k < READS; k++) begin
      @(negedge clk);
      want = seed + 8'(TURN) + 8'(k);
      if (uio_in !== want) mis++;
      check("bus_safe", (uio_oe != 8'h00) && uo_out[1], 0);
      if (k == READS - 1) check("last_read_busy", uo_out[2], 1);
      @(posedge clk);
    end
    #1;
    check("done_busy", uo_out[2], 0);
    check("done_oe_o", uo_out[1], 0);
    check("done_uio_oe", uio_oe, 8'h00);
    check("done_pass", uo_out[3], (mis == 0));
    check("done_fail", uo_out[4], (mis != 0));
    check("done_err", uo_out[7:5], (mis > 7) ? 7 : mis);
    if (hold) begin
      repeat (3) @(posedge clk);
      #1;
      check("held_start_no_rerun", uo_out[2], 0);
      check("held_start_pass_kept", uo_out[3], (mis == 0));
      @(negedge clk); ui_in[0] = 1'b0;
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: observed timeout, required $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [5:0] s6;
    logic [7:0] fv;
    int mode;
    rst_n = 1'b0; ui_in = 8'h00;
    stuck_on = 1'b0; fault_on = 1'b0; fault_val = 8'h00;
    #1;
    check("reset_uo_out", uo_out, 8'h00);
    check("reset_uio_out", uio_out, 8'h00);
    check("reset_uio_oe", uio_oe, 8'h00);
    repeat (3) @(posedge clk);
    #1;
    check("reset_hold_uo_out", uo_out, 8'h00);
    @(negedge clk); rst_n = 1'b1;
    repeat (2) @(posedge clk);

    // Seed 0x03, good counter, start held high afterwards
    run_one(6'h00, 0, 8'h00, 1'b1);
    // Seed 0xFF: readback wraps through 0x00
    run_one(6'h3F, 0, 8'h00, 1'b0);
    check("wrap_pass", uo_out[3], 1);
    // Counter skips 0x09 at sample 5
    run_one(6'h00, 2, 8'h09, 1'b0);
    check("skip_fail", uo_out[4], 1);
    check("skip_pass", uo_out[3], 0);
    check("skip_err_sat", uo_out[7:5], 3'd7);
    // Stuck-at-zero bus
    run_one(6'h00, 1, 8'h00, 1'b0);
    check("stuck_err_sat", uo_out[7:5], 3'd7);
    check("stuck_busy", uo_out[2], 0);

    // Abort in the third READ cycle, then a start while abort is high
    stuck_on = 1'b1; fault_on = 1'b0;
    @(negedge clk); ui_in = 8'h00;
    @(negedge clk);
    @(negedge clk); ui_in = 8'h01;
    @(posedge clk);
    @(negedge clk); ui_in[0] = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("pre_abort_err", uo_out[7:5], 3'd2);
    check("pre_abort_oe_o", uo_out[1], 1);
    @(negedge clk); ui_in[1] = 1'b1;
    @(posedge clk); #1;
    check("abort_oe_o", uo_out[1], 0);
    check("abort_uio_oe", uio_oe, 8'h00);
    check("abort_busy", uo_out[2], 0);
    check("abort_results", uo_out[7:3], 5'd0);
    @(negedge clk); ui_in[0] = 1'b1;
    @(posedge clk); #1;
    check("abort_start_uio_oe", uio_oe, 8'h00);
    check("abort_start_load", uo_out[0], 0);
    @(posedge clk); #1;
    check("abort_start_busy", uo_out[2], 0);
    @(negedge clk); ui_in[1] = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("abort_release_busy", uo_out[2], 0);
    check("abort_release_uio_oe", uio_oe, 8'h00);
    stuck_on = 1'b0;

    // Reset asserted during WRITE, start held high across release
    @(negedge clk); ui_in = 8'h00;
    @(negedge clk);
    @(negedge clk); ui_in = {6'h05, 2'b01};
    @(posedge clk); #1;
    check("rst_pre_write", uio_oe, 8'hFF);
    #2; rst_n = 1'b0;
    #1;
    check("rst_uio_oe", uio_oe, 8'h00);
    check("rst_uo_out", uo_out, 8'h00);
    @(negedge clk); rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check("rst_release_busy", uo_out[2], 0);
    check("rst_release_uio_oe", uio_oe, 8'h00);
    check("rst_release_load", uo_out[0], 0);

    // Randomized runs across all responder behaviours
    for (int i = 0; i < 6; i++) begin
      s6   = 6'($urandom);
      mode = $urandom_range(0, 2);
      fv   = {s6, 2'b11} + 8'(TURN) + 8'($urandom_range(1, 15));
      run_one(s6, mode, fv, 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
